// File: rtl/program_loader.sv
// Boot loader: takes a LEN/payload/CSUM byte frame over valid/ready, writes the
// payload into CPU memory, and releases the CPU after a good checksum plus a hold delay.
module program_loader #(
    parameter logic [7:0] BASE_ADR    = 8'h00,
    parameter int         HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_adr,
    output logic [7:0] mem_wd,
    output logic       cpu_reset,
    output logic       load_done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE, LOAD, CHECK, HOLD, RUN, ERROR
    } state_t;

    state_t     state, next_state;
    logic [7:0] len, count, sum, hold_cnt;
    logic       xfer;

    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE) || (state == LOAD) || (state == CHECK);
        xfer       = in_valid && in_ready;
        unique case (state)
            IDLE: begin
                if (xfer) next_state = (in_data == 8'd0) ? ERROR : LOAD;
            end
            LOAD: begin
                if (xfer && (8'(count + 8'd1) == len)) next_state = CHECK;
            end
            CHECK: begin
                if (xfer) next_state = (in_data == sum) ? HOLD : ERROR;
            end
            HOLD: begin
                // counter reaches zero on this edge
                if (hold_cnt <= 8'd1) next_state = RUN;
            end
            RUN:     next_state = RUN;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= 8'd0;
            mem_wd    <= 8'd0;
            len       <= 8'd0;
            count     <= 8'd0;
            sum       <= 8'd0;
            hold_cnt  <= 8'd0;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != RUN);
            load_done <= (next_state == RUN);
            error     <= (next_state == ERROR);
            mem_we    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer && in_data != 8'd0) begin
                        len   <= in_data;
                        count <= 8'd0;
                        sum   <= 8'd0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem_we  <= 1'b1;
                        mem_adr <= 8'(BASE_ADR + count);
                        mem_wd  <= in_data;
                        sum     <= 8'(sum + in_data);
                        count   <= 8'(count + 8'd1);
                    end
                end
                CHECK: begin
                    if (xfer) hold_cnt <= 8'(HOLD_CYCLES);
                end
                HOLD: hold_cnt <= 8'(hold_cnt - 8'd1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 00 and FE) share the stream;
// table vectors, hand sequences and random frames vs a frame-level model.
module tb_program_loader;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rdy0, we0, crst0, done0, err0;
    logic       rdy1, we1, crst1, done1, err1;
    logic [7:0] adr0, wd0, adr1, wd1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    int          dbl;
    bit          prev_we;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADR(8'h00), .HOLD_CYCLES(HOLD)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_we(we0), .mem_adr(adr0), .mem_wd(wd0),
        .cpu_reset(crst0), .load_done(done0), .error(err0)
    );

    program_loader #(.BASE_ADR(8'hFE), .HOLD_CYCLES(HOLD)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_adr(adr1), .mem_wd(wd1),
        .cpu_reset(crst1), .load_done(done1), .error(err1)
    );

    // write log and back-to-back strobe detector, sampled mid-cycle
    always @(negedge clk) begin
        if (we0) wq0.push_back({adr0, wd0});
        if (we1) wq1.push_back({adr1, wd1});
        if (we0 && prev_we) dbl++;
        prev_we = we0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check({name, " rst cpu_reset"}, 32'(crst0), 1);
        check({name, " rst load_done"}, 32'(done0), 0);
        check({name, " rst error"}, 32'(err0), 0);
        check({name, " rst mem_we"}, 32'(we0), 0);
        check({name, " rst mem_adr"}, 32'(adr0), 0);
        check({name, " rst in_ready"}, 32'(rdy0), 1);
        reset = 1'b1;
    endtask

    // Waits (bounded) for a handshake; returns at posedge+1 with in_valid low.
    task automatic send(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 20; c++) begin
            if (rdy0) begin
                tick();
                in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Frame-level reference: expected writes and final outcome.
    function automatic void model(input logic [7:0] f[$], input logic [7:0] base,
                                  output logic [15:0] w[$], output bit d,
                                  output bit e);
        logic [7:0] s;
        int         len;
        w.delete();
        s   = 8'd0;
        len = int'(f[0]);
        d   = 1'b0;
        e   = 1'b0;
        if (len == 0) begin
            e = 1'b1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w.push_back({8'((int'(base) + i) % 256), f[1 + i]});
            s = 8'((int'(s) + int'(f[1 + i])) % 256);
        end
        e = (f[len + 1] != s);
        d = !e;
    endfunction

    task automatic run_frame(input string name, input logic [7:0] f[$],
                             input bit gap, input bit ed, input bit ee);
        logic [15:0] w0[$];
        logic [15:0] w1[$];
        bit          md, me, ok;
        int          len;
        do_reset(name);
        wq0.delete();
        wq1.delete();
        dbl = 0;
        model(f, 8'h00, w0, md, me);
        model(f, 8'hFE, w1, md, me);
        len = int'(f[0]);
        for (int i = 0; i < f.size(); i++) begin
            if (gap && i > 0) tick();
            send(f[i], ok);
            if (!ok) begin
                check({name, " accept"}, 0, 1);
                break;
            end
            if (i >= 1 && i <= len) begin
                check({name, " we lat"}, 32'(we0), 1);
                check({name, " adr lat"}, 32'(adr0), 32'(w0[i - 1][15:8]));
                check({name, " wd lat"}, 32'(wd0), 32'(w0[i - 1][7:0]));
            end
        end
        if (ee) begin
            check({name, " err next"}, 32'(err0), 1);
            check({name, " err crst"}, 32'(crst0), 1);
        end else if (ed) begin
            for (int k = 1; k <= HOLD; k++) begin
                tick();
                check({name, " hold crst"}, 32'(crst0), (k < HOLD) ? 1 : 0);
            end
        end
        repeat (3) tick();
        check({name, " done0"}, 32'(done0), 32'(ed));
        check({name, " err0"}, 32'(err0), 32'(ee));
        check({name, " crst0"}, 32'(crst0), 32'(!ed));
        check({name, " done1"}, 32'(done1), 32'(ed));
        check({name, " err1"}, 32'(err1), 32'(ee));
        check({name, " rdy end"}, 32'(rdy0), 0);
        check({name, " nwr0"}, 32'(wq0.size()), 32'(w0.size()));
        check({name, " nwr1"}, 32'(wq1.size()), 32'(w1.size()));
        for (int j = 0; j < w0.size() && j < wq0.size(); j++)
            check({name, " wr0"}, 32'(wq0[j]), 32'(w0[j]));
        for (int j = 0; j < w1.size() && j < wq1.size(); j++)
            check({name, " wr1"}, 32'(wq1[j]), 32'(w1[j]));
        if (gap) check({name, " we b2b"}, 32'(dbl), 0);
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] b [0:7];
        bit         gap;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t        tbl [0:4];
        logic [7:0]  f[$];
        logic [15:0] w[$];
        bit          md, me, ok;
        int          nw;

        tbl[0] = '{"basic", 5,
                   '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 0, 0, 0}, 0, 1, 0};
        tbl[1] = '{"badsum", 4,
                   '{8'h02, 8'hAA, 8'hBB, 8'h00, 0, 0, 0, 0}, 0, 0, 1};
        tbl[2] = '{"zerolen", 1,
                   '{8'h00, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 1};
        tbl[3] = '{"wrap", 5,
                   '{8'h03, 8'h01, 8'h02, 8'h03, 8'h06, 0, 0, 0}, 0, 1, 0};
        tbl[4] = '{"gaps", 5,
                   '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 0, 0, 0}, 1, 1, 0};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();

        for (int t = 0; t < 5; t++) begin
            f.delete();
            for (int i = 0; i < tbl[t].n; i++) f.push_back(tbl[t].b[i]);
            run_frame(tbl[t].name, f, tbl[t].gap, tbl[t].exp_done,
                      tbl[t].exp_err);
            if (t == 1) begin
                // a new frame after an error is refused
                nw = wq0.size();
                in_valid = 1'b1;
                in_data  = 8'h01;
                for (int c = 0; c < 3; c++) begin
                    check("post-err in_ready", 32'(rdy0), 0);
                    tick();
                end
                in_valid = 1'b0;
                tick();
                check("post-err no we", 32'(wq0.size()), 32'(nw));
            end
        end

        // abort a load after two payload bytes, then reload fully
        do_reset("abort");
        send(8'h03, ok);
        send(8'h11, ok);
        send(8'h22, ok);
        check("abort mid we", 32'(we0), 1);
        f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("reload", f, 0, 1, 0);

        for (int r = 0; r < 30; r++) begin
            int         len;
            logic [7:0] s;
            f.delete();
            len = $urandom_range(1, 12);
            f.push_back(8'(len));
            s = 8'd0;
            for (int i = 0; i < len; i++) begin
                f.push_back(8'($urandom_range(0, 255)));
                s = 8'((int'(s) + int'(f[i + 1])) % 256);
            end
            if ($urandom_range(0, 3) == 0)
                s = 8'((int'(s) + $urandom_range(1, 255)) % 256);
            f.push_back(s);
            model(f, 8'h00, w, md, me);
            run_frame("rand", f, 1'($urandom_range(0, 1)), md, me);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
